// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU op sequencer: op codes, FSM encoding and
// the latency counter width.
package alu_ctrl_pkg;

  localparam int CNT_W = 6;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_ROL = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_NEG = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU drive and response signals of the sequencer.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high; the sender holds valid and its payload
// stable until that edge, and ready may change freely.
interface alu_op_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_zhi;
  logic [31:0] alu_zlo;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;

  // Requester + ALU side.
  modport master (
    output req_valid, req_op, req_a, req_b, alu_zhi, alu_zlo, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_zhi, alu_zlo, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational op classifier: execution latency, illegal op and divide by
// zero. Also usable by the control unit for hazard timing.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int SIMPLE_CYCLES = 1,
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 32
) (
  input  logic [3:0]       op,
  input  logic [31:0]      b,
  output logic [CNT_W-1:0] latency,
  output logic             illegal,
  output logic             div_by_zero
);

  always_comb begin
    latency = CNT_W'(SIMPLE_CYCLES);
    illegal = 1'b0;
    case (op)
      OP_MUL: latency = CNT_W'(MUL_CYCLES);
      OP_DIV: latency = CNT_W'(DIV_CYCLES);
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_NEG, OP_NOT: latency = CNT_W'(SIMPLE_CYCLES);
      default: illegal = 1'b1;
    endcase
  end

  assign div_by_zero = (op == OP_DIV) && (b == 32'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/retire controller in front of the shared ALU: accepts one op, drives
// the ALU for the op's fixed latency, then returns the captured result.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int SIMPLE_CYCLES = 1,
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 32
) (
  input  logic             clk,
  input  logic             clr,
  alu_op_sequencer_if.slave bus,
  output state_t           dbg_state,
  output logic [CNT_W-1:0] dbg_count
);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [31:0]      a_q, a_n, b_q, b_n, hi_q, hi_n, lo_q, lo_n;
  logic [3:0]       ctrl_q, ctrl_n;
  logic             err_q, err_n;

  logic [CNT_W-1:0] latency;
  logic             illegal, div_by_zero;

  alu_op_decode #(
    .SIMPLE_CYCLES (SIMPLE_CYCLES),
    .MUL_CYCLES    (MUL_CYCLES),
    .DIV_CYCLES    (DIV_CYCLES)
  ) u_decode (
    .op          (bus.req_op),
    .b           (bus.req_b),
    .latency     (latency),
    .illegal     (illegal),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      count  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      ctrl_q <= OP_NOP;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      a_q    <= a_n;
      b_q    <= b_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      ctrl_q <= ctrl_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    ctrl_n  = ctrl_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          a_n = bus.req_a;
          b_n = bus.req_b;
          // Rejected ops skip EXEC so the ALU never sees them.
          if (illegal || div_by_zero) begin
            hi_n    = '0;
            lo_n    = '0;
            err_n   = 1'b1;
            state_n = RESP;
          end else begin
            count_n = latency - 1'b1;
            ctrl_n  = bus.req_op;
            state_n = EXEC;
          end
        end
      end
      EXEC: begin
        if (count == '0) begin
          hi_n    = bus.alu_zhi;
          lo_n    = bus.alu_zlo;
          err_n   = 1'b0;
          ctrl_n  = OP_NOP;
          state_n = RESP;
        end else begin
          count_n = count - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_lo    = lo_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state;
  assign dbg_count     = count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table of single ops plus
// hand-written backpressure and mid-divide reset sequences.
module tb_alu_op_sequencer;
  import alu_ctrl_pkg::*;

  localparam int W = 65;  // {hi, lo, err}

  logic clk;
  logic clr;
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_count;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .SIMPLE_CYCLES (1),
    .MUL_CYCLES    (4),
    .DIV_CYCLES    (32)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU reference model ----------------
  always_comb begin
    logic [63:0] rot;
    rot         = '0;
    bus.alu_zhi = '0;
    bus.alu_zlo = '0;
    case (bus.alu_ctrl)
      4'b0000: bus.alu_zlo = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_zlo = bus.alu_a - bus.alu_b;
      4'b0010: {bus.alu_zhi, bus.alu_zlo} = 64'(bus.alu_a) * 64'(bus.alu_b);
      4'b0011: if (bus.alu_b != 0) begin
        bus.alu_zlo = bus.alu_a / bus.alu_b;
        bus.alu_zhi = bus.alu_a % bus.alu_b;
      end
      4'b0100: bus.alu_zlo = bus.alu_a >> bus.alu_b[4:0];
      4'b0101: bus.alu_zlo = bus.alu_a << bus.alu_b[4:0];
      4'b0110: begin
        rot = {bus.alu_a, bus.alu_a} >> bus.alu_b[4:0];
        bus.alu_zlo = rot[31:0];
      end
      4'b0111: begin
        rot = {bus.alu_a, bus.alu_a} << bus.alu_b[4:0];
        bus.alu_zlo = rot[63:32];
      end
      4'b1000: bus.alu_zlo = bus.alu_a & bus.alu_b;
      4'b1001: bus.alu_zlo = bus.alu_a | bus.alu_b;
      4'b1010: bus.alu_zlo = -bus.alu_a;
      4'b1011: bus.alu_zlo = ~bus.alu_a;
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          edges;  // edges after the accepting edge until rsp_valid is seen
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } vec_t;

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the handshake edge.
  task automatic run_op(input vec_t v);
    int n;
    int ctrl_hits;
    logic rdy_bad;
    logic [W-1:0] exp;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({v.name, "_ready_idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    exp_q.push_back({v.hi, v.lo, v.err});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0; ctrl_hits = 0; rdy_bad = 1'b0;
    while (!bus.rsp_valid && n < 200) begin
      if (bus.alu_ctrl == v.op) ctrl_hits++;
      if (bus.req_ready) rdy_bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    check({v.name, "_latency"}, 64'(n), 64'(v.edges));
    check({v.name, "_ctrl_cycles"}, 64'(ctrl_hits), 64'(v.err ? 0 : v.edges));
    check({v.name, "_ready_low"}, 64'(rdy_bad | bus.req_ready), 64'd0);
    check({v.name, "_ctrl_nop"}, 64'(bus.alu_ctrl), 64'(OP_NOP));
    exp = exp_q.pop_front();
    check({v.name, "_hi"}, 64'(bus.rsp_hi), 64'(exp[64:33]));
    check({v.name, "_lo"}, 64'(bus.rsp_lo), 64'(exp[32:1]));
    check({v.name, "_err"}, 64'(bus.rsp_err), 64'(exp[0]));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({v.name, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    check({v.name, "_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  vec_t vecs[9];
  vec_t v;
  logic [31:0] held_hi, held_lo;
  logic        unstable;
  logic        stale;
  int          n;

  initial begin
    // Rejected ops land in RESP on the accepting edge itself (0 further edges).
    vecs[0] = '{"add",     4'b0000, 32'd7,          32'd5,      1,  32'd0, 32'd12,         1'b0};
    vecs[1] = '{"mul",     4'b0010, 32'hFFFF_FFFF,  32'd2,      4,  32'd1, 32'hFFFF_FFFE,  1'b0};
    vecs[2] = '{"div0",    4'b0011, 32'd100,        32'd0,      0,  32'd0, 32'd0,          1'b1};
    vecs[3] = '{"ill_d",   4'b1101, 32'd9,          32'd9,      0,  32'd0, 32'd0,          1'b1};
    vecs[4] = '{"sub",     4'b0001, 32'd3,          32'd5,      1,  32'd0, 32'hFFFF_FFFE,  1'b0};
    vecs[5] = '{"div",     4'b0011, 32'd100,        32'd7,      32, 32'd2, 32'd14,         1'b0};
    vecs[6] = '{"and",     4'b1000, 32'h0000_F0F0,  32'h0000_FF00, 1, 32'd0, 32'h0000_F000, 1'b0};
    vecs[7] = '{"ill_f",   4'b1111, 32'd1,          32'd1,      0,  32'd0, 32'd0,          1'b1};
    vecs[8] = '{"rol",     4'b0111, 32'h8000_0001,  32'd4,      1,  32'd0, 32'h0000_0018,  1'b0};

    clr = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    // Reset state
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_count", 64'(dbg_count), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_alu_b", 64'(bus.alu_b), 64'd0);
    check("rst_ctrl", 64'(bus.alu_ctrl), 64'(OP_NOP));
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_hi, bus.rsp_lo}), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Backpressure: response held for 10 cycles with a new request waiting.
    v = '{"bp_first", 4'b0000, 32'd1, 32'd2, 1, 32'd0, 32'd3, 1'b0};
    bus.req_valid = 1'b1; bus.req_op = v.op; bus.req_a = v.a; bus.req_b = v.b;
    @(posedge clk); #1;
    bus.req_op = 4'b0000; bus.req_a = 32'd10; bus.req_b = 32'd20;
    @(posedge clk); #1;
    check("bp_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_lo", 64'(bus.rsp_lo), 64'd3);
    held_hi = bus.rsp_hi; held_lo = bus.rsp_lo; unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.rsp_valid || bus.req_ready || bus.rsp_hi != held_hi || bus.rsp_lo != held_lo)
        unstable = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_stable", 64'(unstable), 64'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp_drop", 64'(bus.rsp_valid), 64'd0);
    check("bp_idle", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp_accept_next", 64'(dbg_state), 64'(EXEC));
    @(posedge clk); #1;
    check("bp_second_lo", 64'(bus.rsp_lo), 64'd30);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp_second_done", 64'(bus.rsp_valid), 64'd0);

    // Reset during a divide, at counter value 15.
    bus.req_valid = 1'b1; bus.req_op = 4'b0011; bus.req_a = 32'd1000; bus.req_b = 32'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (dbg_count != 6'd15 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("rd_reach15", 64'(dbg_count), 64'd15);
    check("rd_in_exec", 64'(dbg_state), 64'(EXEC));
    clr = 1'b1;
    #1;
    check("rd_async_state", 64'(dbg_state), 64'(IDLE));
    check("rd_async_ctrl", 64'(bus.alu_ctrl), 64'(OP_NOP));
    check("rd_async_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) stale = 1'b1;
      @(posedge clk); #1;
    end
    check("rd_no_stale", 64'(stale), 64'd0);
    run_op('{"rd_add", 4'b0000, 32'd40, 32'd2, 1, 32'd0, 32'd42, 1'b0});

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
